// File: rtl/adc3_pkg.sv
// Shared types and sizing for the three-ADC scan scheduler.
package adc3_pkg;
    typedef enum logic [2:0] {
        IDLE, CONV, WAIT_LO, WAIT_HI, READ, WRITE, NEXT, DONE
    } state_t;

    localparam int NCH   = 3;
    localparam int CH_W  = 2;
    localparam int IDX_W = 9;
    localparam logic [7:0] SENTINEL = 8'hFF;
endpackage

// File: rtl/adc3_scan_sched_if.sv
// ADC control/data pins and sample-RAM write port seen by the scheduler.
interface adc3_scan_sched_if;
    import adc3_pkg::*;
    logic [NCH-1:0]        nbusy;
    logic [7:0]            indata;
    logic [NCH-1:0]        nconvst;
    logic [NCH-1:0]        nrd;
    logic [CH_W+IDX_W-1:0] address;
    logic [7:0]            outdata;
    logic                  wr;

    modport master (input nbusy, indata, output nconvst, nrd, address, outdata, wr);
    modport slave  (output nbusy, indata, input nconvst, nrd, address, outdata, wr);
endinterface

// File: rtl/next_ch_sel.sv
// Next enabled channel above cur_i; wraps to the lowest enabled channel when none is left.
module next_ch_sel
    import adc3_pkg::*;
(
    input  logic [NCH-1:0]  mask_i,
    input  logic [CH_W-1:0] cur_i,
    output logic [CH_W-1:0] nxt_o,
    output logic            wrap_o
);
    logic [CH_W-1:0] above;
    logic [CH_W-1:0] low;
    logic            hit;

    // Descending scan: the last match written is the lowest qualifying bit.
    always_comb begin
        above = '0;
        low   = '0;
        hit   = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                low = CH_W'(i);
                if (CH_W'(i) > cur_i) begin
                    above = CH_W'(i);
                    hit   = 1'b1;
                end
            end
        end
        nxt_o  = hit ? above : low;
        wrap_o = !hit;
    end
endmodule

// File: rtl/adc3_scan_sched.sv
// Round-robin conversion sequencer: convert, wait busy, read, write to sample RAM.
module adc3_scan_sched
    import adc3_pkg::*;
#(
    parameter int DEPTH    = 512,
    parameter int CONV_LOW = 2,
    parameter int RD_LOW   = 3,
    parameter int BUSY_TMO = 1024
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic [NCH-1:0]     ch_mask,
    adc3_scan_sched_if.master  bus,
    output logic               running,
    output logic               done,
    output logic               tmo_err
);
    localparam int SMAX = (CONV_LOW > RD_LOW) ? CONV_LOW : RD_LOW;
    localparam int SW   = $clog2(SMAX + 1);
    localparam int TW   = $clog2(BUSY_TMO + 1);

    state_t                state_q;
    logic [NCH-1:0]        mask_q, nb_s1_q, nb_s2_q;
    logic [CH_W-1:0]       ch_q;
    logic [IDX_W-1:0]      idx_q;
    logic [SW-1:0]         cnt_q;
    logic [TW-1:0]         tmo_q;
    logic                  start_q;
    logic [NCH-1:0]        nconvst_q, nrd_q;
    logic [CH_W+IDX_W-1:0] address_q;
    logic [7:0]            outdata_q;
    logic                  wr_q, running_q, done_q, tmo_err_q;

    logic [NCH-1:0]  sel_mask_d;
    logic [CH_W-1:0] sel_cur_d;
    logic [CH_W-1:0] sel_ch;
    logic            sel_wrap;

    // In IDLE the search starts above the top channel, yielding the lowest set bit of the new mask.
    always_comb begin
        sel_mask_d = mask_q;
        sel_cur_d  = ch_q;
        if (state_q == IDLE) begin
            sel_mask_d = ch_mask;
            sel_cur_d  = CH_W'(NCH - 1);
        end
    end

    next_ch_sel u_sel (
        .mask_i (sel_mask_d),
        .cur_i  (sel_cur_d),
        .nxt_o  (sel_ch),
        .wrap_o (sel_wrap)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            nb_s1_q   <= '1;
            nb_s2_q   <= '1;
            ch_q      <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            start_q   <= start;
            nconvst_q <= '1;
            nrd_q     <= '1;
            address_q <= '0;
            outdata_q <= '0;
            wr_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            nb_s1_q <= bus.nbusy;
            nb_s2_q <= nb_s1_q;
            start_q <= start;
            case (state_q)
                IDLE: if (start && !start_q) begin
                    tmo_err_q <= 1'b0;
                    if (ch_mask == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        mask_q            <= ch_mask;
                        idx_q             <= '0;
                        ch_q              <= sel_ch;
                        running_q         <= 1'b1;
                        nconvst_q[sel_ch] <= 1'b0;
                        cnt_q             <= '0;
                        state_q           <= CONV;
                    end
                end
                CONV: if (cnt_q == SW'(CONV_LOW - 1)) begin
                    nconvst_q <= '1;
                    tmo_q     <= '0;
                    state_q   <= WAIT_LO;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                WAIT_LO, WAIT_HI: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (state_q == WAIT_LO && !nb_s2_q[ch_q]) begin
                        state_q <= WAIT_HI;
                    end else if (state_q == WAIT_HI && nb_s2_q[ch_q]) begin
                        nrd_q[ch_q] <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= READ;
                    end else if (tmo_q == TW'(BUSY_TMO - 1)) begin
                        // Dead ADC: record a sentinel so the RAM slot is still filled.
                        tmo_err_q <= 1'b1;
                        outdata_q <= SENTINEL;
                        address_q <= {ch_q, idx_q};
                        wr_q      <= 1'b1;
                        state_q   <= WRITE;
                    end
                end
                READ: if (cnt_q == SW'(RD_LOW - 1)) begin
                    nrd_q     <= '1;
                    outdata_q <= bus.indata;
                    address_q <= {ch_q, idx_q};
                    wr_q      <= 1'b1;
                    state_q   <= WRITE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                WRITE: begin
                    wr_q    <= 1'b0;
                    state_q <= NEXT;
                end
                NEXT: if (sel_wrap && idx_q == IDX_W'(DEPTH - 1)) begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end else begin
                    if (sel_wrap) idx_q <= idx_q + 1'b1;
                    ch_q              <= sel_ch;
                    nconvst_q[sel_ch] <= 1'b0;
                    cnt_q             <= '0;
                    state_q           <= CONV;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.nconvst = nconvst_q;
    assign bus.nrd     = nrd_q;
    assign bus.address = address_q;
    assign bus.outdata = outdata_q;
    assign bus.wr      = wr_q;
    assign running     = running_q;
    assign done        = done_q;
    assign tmo_err     = tmo_err_q;
endmodule

// File: tb/tb_adc3_scan_sched.sv
// Self-checking bench: ADC models, write scoreboard, vector table plus reset/start corner sequences.
module tb_adc3_scan_sched;
    import adc3_pkg::*;

    localparam int DEPTH    = 4;
    localparam int CONV_LOW = 2;
    localparam int RD_LOW   = 3;
    localparam int BUSY_TMO = 64;
    localparam int BUSY_LEN = 10;

    logic       CLK = 1'b0;
    logic       reset, start;
    logic [2:0] ch_mask;
    logic       running, done, tmo_err;

    adc3_scan_sched_if bif();

    adc3_scan_sched #(
        .DEPTH(DEPTH), .CONV_LOW(CONV_LOW), .RD_LOW(RD_LOW), .BUSY_TMO(BUSY_TMO)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .start   (start),
        .ch_mask (ch_mask),
        .bus     (bif.master),
        .running (running),
        .done    (done),
        .tmo_err (tmo_err)
    );

    always #5 CLK = ~CLK;

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ADC models: busy pulses low BUSY_LEN cycles after nconvst returns high; data = ch*16 + sample count.
    logic [2:0] stuck = '0;
    logic [2:0] conv_seen = '0;
    logic [2:0] nrd_prev = '1;
    logic       model_clr = 1'b0;
    int         bcnt [3] = '{0, 0, 0};
    logic [7:0] scnt [3] = '{8'd0, 8'd0, 8'd0};

    always @(posedge CLK) begin
        nrd_prev <= bif.nrd;
        for (int c = 0; c < 3; c++) begin
            if (!bif.nconvst[c]) conv_seen[c] <= 1'b1;
            else if (conv_seen[c]) begin
                conv_seen[c] <= 1'b0;
                bcnt[c]      <= BUSY_LEN;
            end else if (bcnt[c] > 0) bcnt[c] <= bcnt[c] - 1;
            if (model_clr) scnt[c] <= '0;
            else if (!nrd_prev[c] && bif.nrd[c]) scnt[c] <= scnt[c] + 8'd1;
        end
    end

    always_comb begin
        bif.indata = '0;
        for (int c = 0; c < 3; c++) begin
            bif.nbusy[c] = stuck[c] | (bcnt[c] == 0);
            if (!bif.nrd[c]) bif.indata = 8'(c * 16) + scnt[c];
        end
    end

    typedef struct {
        logic [10:0] a;
        logic [7:0]  d;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int         wr_cnt = 0;
    int         done_cnt = 0;
    int         viol = 0;
    logic [2:0] act = '0;

    always @(negedge CLK) begin
        if (bif.wr === 1'b1) begin
            wr_cnt++;
            if (q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_wr: got addr %0h data %0h, required no write", bif.address, bif.outdata);
            end else begin
                e = q.pop_front();
                chk("wr_addr", 32'(bif.address), 32'(e.a));
                chk("wr_data", 32'(bif.outdata), 32'(e.d));
            end
        end
        if (done === 1'b1) done_cnt++;
        for (int c = 0; c < 3; c++) begin
            if (!bif.nconvst[c] || !bif.nrd[c]) act[c] = 1'b1;
            if (!bif.nconvst[c] && !bif.nrd[c]) viol++;
        end
        if (!$onehot0(~bif.nconvst | ~bif.nrd)) viol++;
    end

    task automatic push_exp(input logic [2:0] m, input logic [2:0] stk);
        for (int i = 0; i < DEPTH; i++)
            for (int c = 0; c < 3; c++)
                if (m[c]) q.push_back('{a: 11'(c * 512 + i), d: (stk[c] ? 8'hFF : 8'(c * 16 + i))});
    endtask

    task automatic prep(input logic [2:0] m, input logic [2:0] stk);
        stuck    = stk;
        ch_mask  = m;
        wr_cnt   = 0;
        done_cnt = 0;
        viol     = 0;
        act      = '0;
        model_clr = 1'b1;
        @(negedge CLK);
        model_clr = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (done_cnt == 0 && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 5000) begin
            nchk++;
            nfail++;
            $display("FAIL %s_done_timeout: got no done, required done within 5000 cycles", nm);
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic run_vec(input logic [2:0] m, input logic [2:0] stk, input int nwr, input logic tmo,
                           input string nm);
        prep(m, stk);
        push_exp(m, stk);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        if (m == 3'b000) begin
            chk({nm, "_done_pulse"}, 32'(done), 32'd1);
            chk({nm, "_running"}, 32'(running), 32'd0);
        end else begin
            chk({nm, "_running"}, 32'(running), 32'd1);
            chk({nm, "_tmo_clr"}, 32'(tmo_err), 32'd0);
        end
        wait_done(nm);
        chk({nm, "_wr_cnt"}, 32'(wr_cnt), 32'(nwr));
        chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({nm, "_tmo_err"}, 32'(tmo_err), 32'(tmo));
        chk({nm, "_idle_ch"}, 32'(act & ~m), 32'd0);
        chk({nm, "_order"}, 32'(viol), 32'd0);
        chk({nm, "_end_running"}, 32'(running), 32'd0);
        chk({nm, "_sb_empty"}, 32'(q.size()), 32'd0);
    endtask

    typedef struct {
        logic [2:0] m;
        logic [2:0] stk;
        int         nwr;
        logic       tmo;
        string      nm;
    } vec_t;
    vec_t vt [5];

    initial begin
        vt[0] = '{m: 3'b111, stk: 3'b000, nwr: 12, tmo: 1'b0, nm: "mask111"};
        vt[1] = '{m: 3'b101, stk: 3'b000, nwr: 8,  tmo: 1'b0, nm: "mask101"};
        vt[2] = '{m: 3'b000, stk: 3'b000, nwr: 0,  tmo: 1'b0, nm: "mask000"};
        vt[3] = '{m: 3'b010, stk: 3'b010, nwr: 4,  tmo: 1'b1, nm: "tmo010"};
        vt[4] = '{m: 3'b001, stk: 3'b000, nwr: 4,  tmo: 1'b0, nm: "mask001"};

        reset   = 1'b1;
        start   = 1'b0;
        ch_mask = '0;
        repeat (3) @(negedge CLK);
        chk("rst_nconvst", 32'(bif.nconvst), 32'h7);
        chk("rst_nrd", 32'(bif.nrd), 32'h7);
        chk("rst_addr", 32'(bif.address), 32'h0);
        chk("rst_outdata", 32'(bif.outdata), 32'h0);
        chk("rst_flags", 32'({bif.wr, running, done, tmo_err}), 32'h0);
        reset = 1'b0;
        @(negedge CLK);

        for (int v = 0; v < 5; v++) run_vec(vt[v].m, vt[v].stk, vt[v].nwr, vt[v].tmo, vt[v].nm);

        // Reset while the first sample is being read.
        begin
            int t = 0;
            prep(3'b001, 3'b000);
            start = 1'b1;
            @(negedge CLK);
            start = 1'b0;
            while (bif.nrd[0] !== 1'b0 && t < 500) begin
                @(negedge CLK);
                t++;
            end
            chk("rd_reached", 32'(bif.nrd[0]), 32'd0);
            reset = 1'b1;
            @(negedge CLK);
            reset = 1'b0;
            chk("midrd_nconvst", 32'(bif.nconvst), 32'h7);
            chk("midrd_nrd", 32'(bif.nrd), 32'h7);
            chk("midrd_addr_data", 32'({bif.address, bif.outdata}), 32'h0);
            chk("midrd_flags", 32'({bif.wr, running, done, tmo_err}), 32'h0);
            repeat (10) @(negedge CLK);
            chk("midrd_no_wr", 32'(wr_cnt), 32'd0);
        end
        run_vec(3'b001, 3'b000, 4, 1'b0, "after_rst");

        // Start re-pulsed during a run and held across done: no relaunch.
        prep(3'b111, 3'b000);
        push_exp(3'b111, 3'b000);
        start = 1'b1;
        repeat (30) @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        start = 1'b1;
        wait_done("hold");
        repeat (30) @(negedge CLK);
        chk("hold_running", 32'(running), 32'd0);
        chk("hold_wr_cnt", 32'(wr_cnt), 32'd12);
        chk("hold_done_cnt", 32'(done_cnt), 32'd1);
        chk("hold_sb_empty", 32'(q.size()), 32'd0);
        start = 1'b0;
        @(negedge CLK);
        run_vec(3'b110, 3'b000, 8, 1'b0, "fresh_edge");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
